// File: rtl/my_div_16_if.sv
// my_div_16_if: handshake and operand/result bundle for the iterative divider.
//   start       : request a division (controller -> divider)
//   a, b        : dividend / divisor, sampled with start
//   busy, done  : divider status; done is a one-cycle result strobe
//   q, rem      : registered quotient / remainder, held until the next result
//   div0        : divide-by-zero flag, only when DIV_ZERO_DETECT_EN is defined
// Modports: master = controller side, slave = divider side.
interface my_div_16_if #(parameter int WIDTH = 16);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] rem;
`ifdef DIV_ZERO_DETECT_EN
   logic             div0;

   modport master (output start, a, b, input busy, done, q, rem, div0);
   modport slave  (input start, a, b, output busy, done, q, rem, div0);
`else
   modport master (output start, a, b, input busy, done, q, rem);
   modport slave  (input start, a, b, output busy, done, q, rem);
`endif
endinterface

// File: rtl/my_div_16.sv
// my_div_16: iterative unsigned restoring divider, one trial subtraction per clock.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any division in flight
//   bus   : my_div_16_if.slave (start/a/b in, busy/done/q/rem[/div0] out)
// Optional feature macro: DIV_ZERO_DETECT_EN -- adds div0 and a one-cycle early
// exit when the sampled divisor is zero. Without it a zero divisor runs the full
// sequence and naturally yields q = all ones, rem = a.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on the start edge
// S_CALC | one shift/trial-subtract iteration per edge, WIDTH iterations
// S_FIN  | result registered, done high for this single cycle
module my_div_16 #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   my_div_16_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] dvd_q;    // dividend shifts out MSB-first, quotient fills from LSB
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH-1:0] prem_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] rem_q;
   logic             busy_q;
   logic             done_q;
`ifdef DIV_ZERO_DETECT_EN
   logic             div0_q;
`endif

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             qbit;
   logic [WIDTH-1:0] prem_d;
   logic [WIDTH-1:0] dvd_d;
   logic [CW-1:0]    cnt_d;
   logic             last_iter;

   // Shifted remainder can reach 2*divisor-1, so the trial runs one bit wider;
   // its MSB is the borrow that decides restore vs. keep.
   always_comb begin
      shifted   = {prem_q, dvd_q[WIDTH-1]};
      trial     = shifted - {1'b0, dsr_q};
      qbit      = ~trial[WIDTH];
      prem_d    = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      dvd_d     = {dvd_q[WIDTH-2:0], qbit};
      cnt_d     = cnt_q + 1'b1;
      last_iter = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         prem_q  <= '0;
         q_q     <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
         div0_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  dvd_q  <= bus.a;
                  dsr_q  <= bus.b;
                  prem_q <= '0;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                  if (bus.b == '0) begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                     q_q     <= '1;
                     rem_q   <= bus.a;
                     div0_q  <= 1'b1;
                  end else begin
                     state_q <= S_CALC;
                  end
`else
                  state_q <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               prem_q <= prem_d;
               dvd_q  <= dvd_d;
               cnt_q  <= cnt_d;
               if (last_iter) begin
                  state_q <= S_FIN;
                  done_q  <= 1'b1;
                  q_q     <= dvd_d;
                  rem_q   <= prem_d;
`ifdef DIV_ZERO_DETECT_EN
                  div0_q  <= 1'b0;
`endif
               end
            end
            S_FIN: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.q    = q_q;
   assign bus.rem  = rem_q;
`ifdef DIV_ZERO_DETECT_EN
   assign bus.div0 = div0_q;
`endif
endmodule
